// File: rtl/ca_pkg.sv
// Shared types and constants for the chromatic-adaption stream arbiter.
package ca_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } ca_pixel_t;

  typedef enum logic [1:0] {
    CA_IDLE   = 2'd0,
    CA_GRANT0 = 2'd1,
    CA_GRANT1 = 2'd2
  } ca_arb_state_e;

  localparam logic CA_SRC_LIVE = 1'b0;
  localparam logic CA_SRC_CAL  = 1'b1;

endpackage

// File: rtl/ca_tag_fifo.sv
// 1-bit tag FIFO recording which source issued each pixel currently inside the core.
module ca_tag_fifo
  import ca_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     push_tag,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic                     head_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [DEPTH-1:0] mem;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign count    = wptr - rptr;
  assign head_tag = mem[rptr[AW-1:0]];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_tag;
  end

endmodule

// File: rtl/ca_stream_arbiter.sv
// Two-source burst-limited round-robin arbiter sharing one adaption core, with tag-routed returns.
// Optional per-source beat counters are built when CA_ARB_STATS_EN is defined.
module ca_stream_arbiter
  import ca_pkg::*;
#(
  parameter int DATA_W       = 24,
  parameter int MAX_INFLIGHT = 8,
  parameter int BURST_MAX    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             s0_data,
  input  logic                          s0_valid,
  output logic                          s0_ready,
  input  logic [DATA_W-1:0]             s1_data,
  input  logic                          s1_valid,
  output logic                          s1_ready,
  output logic [DATA_W-1:0]             core_in_data,
  output logic                          core_in_valid,
  input  logic                          core_in_ready,
  input  logic [DATA_W-1:0]             core_out_data,
  input  logic                          core_out_valid,
  output logic                          core_out_ready,
  output logic [DATA_W-1:0]             m0_data,
  output logic                          m0_valid,
  input  logic                          m0_ready,
  output logic [DATA_W-1:0]             m1_data,
  output logic                          m1_valid,
  input  logic                          m1_ready,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          orphan_err,
  output logic [15:0]                   stat0_cnt,
  output logic [15:0]                   stat1_cnt
);

  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  ca_arb_state_e state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          fifo_full, fifo_empty, head_tag;
  logic          beat0, beat1, push, pop;

  // Forward path: granted source straight through to the core, gated by tag space.
  always_comb begin
    core_in_data  = '0;
    core_in_valid = 1'b0;
    s0_ready      = 1'b0;
    s1_ready      = 1'b0;
    case (state)
      CA_GRANT0: begin
        core_in_data  = s0_data;
        core_in_valid = s0_valid & ~fifo_full;
        s0_ready      = core_in_ready & ~fifo_full;
      end
      CA_GRANT1: begin
        core_in_data  = s1_data;
        core_in_valid = s1_valid & ~fifo_full;
        s1_ready      = core_in_ready & ~fifo_full;
      end
      default: ;
    endcase
  end

  assign beat0 = s0_valid & s0_ready;
  assign beat1 = s1_valid & s1_ready;
  assign push  = beat0 | beat1;

  always_comb begin
    state_nxt      = state;
    burst_nxt      = burst_cnt;
    last_grant_nxt = last_grant;
    case (state)
      CA_IDLE: begin
        if (s0_valid && (!s1_valid || last_grant == CA_SRC_CAL)) state_nxt = CA_GRANT0;
        else if (s1_valid)                                       state_nxt = CA_GRANT1;
      end
      CA_GRANT0: begin
        if (!s0_valid) begin
          burst_nxt = '0;
          state_nxt = s1_valid ? CA_GRANT1 : CA_IDLE;
        end else if (beat0) begin
          if (burst_cnt == BURST_LAST) begin
            burst_nxt = '0;
            if (s1_valid) state_nxt = CA_GRANT1;
          end else begin
            burst_nxt = burst_cnt + BW'(1);
          end
        end
      end
      CA_GRANT1: begin
        if (!s1_valid) begin
          burst_nxt = '0;
          state_nxt = s0_valid ? CA_GRANT0 : CA_IDLE;
        end else if (beat1) begin
          if (burst_cnt == BURST_LAST) begin
            burst_nxt = '0;
            if (s0_valid) state_nxt = CA_GRANT0;
          end else begin
            burst_nxt = burst_cnt + BW'(1);
          end
        end
      end
      default: state_nxt = CA_IDLE;
    endcase
    if (state_nxt == CA_GRANT0 && state != CA_GRANT0) last_grant_nxt = CA_SRC_LIVE;
    if (state_nxt == CA_GRANT1 && state != CA_GRANT1) last_grant_nxt = CA_SRC_CAL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CA_IDLE;
      last_grant <= CA_SRC_CAL;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  ca_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_tag (beat1),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_tag (head_tag),
    .count    (inflight)
  );

  // Return path: the head tag selects the requester; with no tag the result is swallowed.
  always_comb begin
    m0_data        = core_out_data;
    m1_data        = core_out_data;
    m0_valid       = 1'b0;
    m1_valid       = 1'b0;
    core_out_ready = 1'b1;
    if (!fifo_empty) begin
      if (head_tag == CA_SRC_CAL) begin
        m1_valid       = core_out_valid;
        core_out_ready = m1_ready;
      end else begin
        m0_valid       = core_out_valid;
        core_out_ready = m0_ready;
      end
    end
  end

  assign pop = core_out_valid & core_out_ready & ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           orphan_err <= 1'b0;
    else if (core_out_valid && fifo_empty) orphan_err <= 1'b1;
  end

`ifdef CA_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_cnt <= '0;
      stat1_cnt <= '0;
    end else begin
      if (beat0) stat0_cnt <= sat_inc(stat0_cnt);
      if (beat1) stat1_cnt <= sat_inc(stat1_cnt);
    end
  end
`else
  assign stat0_cnt = '0;
  assign stat1_cnt = '0;
`endif

endmodule

// File: doc/ca_stream_arbiter.md
# ca_stream_arbiter

Two-source pixel arbiter in front of `chromatic_adaption_top`. It shares the single adaption core between a live source (port 0, e.g. camera/video) and a calibration/test source (port 1). Burst-limited round-robin grants feed the core's valid/ready input. A tag FIFO records the source of every accepted pixel and routes each core result back to the requester that issued it.

## Interface
- `DATA_W`, 24: RGB pixel width (8:8:8).
- `MAX_INFLIGHT`, 8: tag FIFO depth; power of two, ≥2; caps core occupancy.
- `BURST_MAX`, 16: maximum consecutive beats granted to one source while the other is requesting.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s0_data`/`s1_data` in DATA_W: requester pixels.
- `s0_valid`/`s1_valid` in 1: requester valid.
- `s0_ready`/`s1_ready` out 1: requester ready.
- `core_in_data` out DATA_W: to core `input_rgb_data`.
- `core_in_valid` out 1, `core_in_ready` in 1: core input handshake.
- `core_out_data` in DATA_W, `core_out_valid` in 1, `core_out_ready` out 1: core result handshake.
- `m0_data`/`m1_data` out DATA_W, `m0_valid`/`m1_valid` out 1, `m0_ready`/`m1_ready` in 1: per-requester result streams.
- `inflight` out $clog2(MAX_INFLIGHT)+1: current tag FIFO occupancy.
- `orphan_err` out 1: sticky; core result arrived with empty tag FIFO.
- `stat0_cnt`/`stat1_cnt` out 16: per-source accepted-beat counters (see Configuration).

## Operation
- States: IDLE, GRANT0, GRANT1. `last_grant` resets to 1, so port 0 wins the first tie.
- IDLE: no transfer. If `s0_valid` and (`!s1_valid` or `last_grant==1`), go to GRANT0. Else if `s1_valid`, go to GRANT1.
- GRANTx: `core_in_data=sx_data`, `core_in_valid=sx_valid & !full`, `sx_ready=core_in_ready & !full`; the other `sy_ready=0`.
- Beat = `sx_valid & sx_ready`. A beat pushes tag x and increments `burst_cnt`.
- Beat with `burst_cnt==BURST_MAX-1`: clear `burst_cnt`. Go to GRANTy if `sy_valid`, else stay in GRANTx.
- `!sx_valid`: go to GRANTy if `sy_valid` (clear `burst_cnt`), else go to IDLE. `last_grant` updates on every GRANT entry.
- Full blocks push even if a pop occurs in the same cycle. Empty blocks pop. Simultaneous push and pop when neither full nor empty leaves `inflight` unchanged.
- Return path with tag t at the FIFO head: `mt_data=core_out_data`, `mt_valid=core_out_valid`, `core_out_ready=mt_ready`. Pop on `core_out_valid & core_out_ready`. The non-addressed `m*_valid=0`.
- FIFO empty: `core_out_ready=1`. Any `core_out_valid` is dropped and sets `orphan_err`, which is cleared only by reset.
- FIFO pointers are $clog2(MAX_INFLIGHT)+1 bits and wrap naturally. Full when MSBs differ and the other bits are equal.

## Timing
- Reset values: state IDLE; `burst_cnt`, FIFO pointers, `inflight`, `orphan_err`, `stat*_cnt` all 0; all `*_valid`/`*_ready` outputs 0 except `core_out_ready=1` (FIFO empty).
- Arbitration latency from IDLE: 1 cycle. The first beat can occur in the cycle after `sx_valid` rises.
- Source switch GRANTx→GRANTy: no bubble. The first y beat is possible in the cycle after the last x beat.
- Forward data path and return data path are combinational, zero added latency. Only state, counters and FIFO are registered.
- A source may drop `valid` without a beat. No stability of requester data is required beyond the standard valid/ready rule.
- Reset mid-operation flushes all tags. Late core results after reset are orphans and set `orphan_err`. The integration resets the core on the same `rst_n`.

## Configuration
- `CA_ARB_STATS_EN` defined: `stat0_cnt`/`stat1_cnt` count accepted beats per source, saturating at 16'hFFFF.
- Not defined: counter logic is absent and both ports are tied to 0. All other behaviour is identical.

## Structure
- Shared package `ca_pkg`:
  - `ca_pixel_t` (24-bit packed R,G,B).
  - Arbiter state enum `ca_arb_state_e`.
  - Source ID constants `CA_SRC_LIVE=0`, `CA_SRC_CAL=1`.
- One sub-module, `ca_tag_fifo`: 1-bit-wide synchronous FIFO (depth `MAX_INFLIGHT`) with full, empty and count outputs. The arbiter FSM and return mux stay in `ca_stream_arbiter`.

## Test plan
- Only s0 streams 40 beats, core always ready → all 40 accepted back-to-back with no switch; `m0` receives 40 results in order; `inflight` returns to 0.
- s0 and s1 both continuously valid, BURST_MAX=16 → grant pattern 16×s0, 16×s1, 16×s0…, with no idle cycle at switches.
- Core holds `core_out_valid=0` → after 8 accepted beats, `s*_ready=0` and `inflight=8`. Release → drains in order and acceptance resumes.
- Interleaved tags {0,0,1,0,1} with `m1_ready=0` → the 3rd result stalls (`core_out_ready=0`) and the 4th/5th are not delivered until `m1_ready=1`.
- Core asserts `core_out_valid` with FIFO empty → beat dropped, `orphan_err=1` and remains 1 until `rst_n` is pulsed.
- With `CA_ARB_STATS_EN`: 70000 s1 beats → `stat1_cnt=16'hFFFF` and `stat0_cnt=0`. Without the macro both read 0.
